seg_bank_scanner: RTL



---
 rtl/seg_bank_scanner_if.sv | 24 ++
 rtl/seg_bank_scanner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg_bank_scanner_if.sv
// Bundle for seg_bank_scanner: capture inputs and bank select from the display
// side, plus the scanned 8-digit outputs.
`timescale 1ns/1ps
interface seg_bank_scanner_if;
  logic [63:0] seg_bus;
  logic [3:0]  sl_in;
  logic        freeze;
  logic [1:0]  bank_sel;
  logic [7:0]  seg_out;
  logic [7:0]  an_n;
  logic [1:0]  shown_bank;
  logic        frame_start;
  logic [3:0]  bank_valid;

  modport master (
    output seg_bus, sl_in, freeze, bank_sel,
    input  seg_out, an_n, shown_bank, frame_start, bank_valid
  );

  modport slave (
    input  seg_bus, sl_in, freeze, bank_sel,
    output seg_out, an_n, shown_bank, frame_start, bank_valid
  );
endinterface

// File: rtl/seg_bank_scanner.sv
// Captures four rotating 7-segment banks and scans one selected bank onto an
// 8-digit multiplexed display. Optional LEADING_ZERO_BLANK_EN blanks leading '0's.
`timescale 1ns/1ps
module seg_bank_scanner #(
  parameter int ON_CYC    = 1,
  parameter int BLANK_CYC = 0
) (
  input  logic                clk_300Hz,
  input  logic                rst_n,
  seg_bank_scanner_if.slave   bus
);

  typedef enum logic [1:0] {LATCH, BLANK, ON} state_t;

  localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYC > 0);

  state_t          state, nxt_state;
  logic [2:0]      digit, nxt_digit;
  logic [CW-1:0]   phase, nxt_phase;
  logic            enter_on;

  logic [63:0]     bank_buf [4];
  logic [3:0]      valid_q;
  logic            cap_en;
  logic [1:0]      cap_idx;

  logic [1:0]      nxt_bank;
  logic [63:0]     cur_word;
  logic [7:0]      cur_pat;

  logic [7:0]      seg_q, an_q;
  logic [1:0]      shown_q;
  logic            fs_q;

  always_comb begin
    cap_en  = 1'b0;
    cap_idx = 2'd0;
    if (!bus.freeze) begin
      case (bus.sl_in)
        4'b1000: begin cap_en = 1'b1; cap_idx = 2'd0; end
        4'b0100: begin cap_en = 1'b1; cap_idx = 2'd1; end
        4'b0010: begin cap_en = 1'b1; cap_idx = 2'd2; end
        4'b0001: begin cap_en = 1'b1; cap_idx = 2'd3; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_300Hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) bank_buf[i] <= 64'h0;
      valid_q <= 4'b0000;
    end else if (cap_en) begin
      bank_buf[cap_idx] <= bus.seg_bus;
      valid_q[cap_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk_300Hz or negedge rst_n) begin
    if (!rst_n) begin
      state <= LATCH;
      digit <= 3'd0;
      phase <= '0;
    end else begin
      state <= nxt_state;
      digit <= nxt_digit;
      phase <= nxt_phase;
    end
  end

  // enter_on marks the cycle a digit is first lit, so its pattern is sampled once per digit
  always_comb begin
    nxt_state = state;
    nxt_digit = digit;
    nxt_phase = phase;
    enter_on  = 1'b0;
    unique case (state)
      LATCH: begin
        nxt_phase = '0;
        if (HAS_BLANK) begin
          nxt_state = BLANK;
        end else begin
          nxt_state = ON;
          enter_on  = 1'b1;
        end
      end
      BLANK: begin
        if (phase == BLANK_LAST) begin
          nxt_phase = '0;
          nxt_state = ON;
          enter_on  = 1'b1;
        end else begin
          nxt_phase = phase + 1'b1;
        end
      end
      ON: begin
        if (phase == ON_LAST) begin
          nxt_phase = '0;
          if (digit == 3'd7) begin
            nxt_digit = 3'd0;
            nxt_state = LATCH;
          end else begin
            nxt_digit = digit + 3'd1;
            if (HAS_BLANK) begin
              nxt_state = BLANK;
            end else begin
              nxt_state = ON;
              enter_on  = 1'b1;
            end
          end
        end else begin
          nxt_phase = phase + 1'b1;
        end
      end
      default: nxt_state = LATCH;
    endcase
  end

  always_comb begin
    nxt_bank = (state == LATCH) ? bus.bank_sel : shown_q;
    cur_word = valid_q[nxt_bank] ? bank_buf[nxt_bank] : 64'h0;
    cur_pat  = cur_word[{nxt_digit, 3'b000} +: 8];
`ifdef LEADING_ZERO_BLANK_EN
    begin : lz_blank
      logic lz_run;
      lz_run = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if ((2'(i) <= nxt_digit[1:0]) &&
            (cur_word[{nxt_digit[2], 2'(i), 3'b000} +: 8] != 8'hFC))
          lz_run = 1'b0;
      end
      if ((nxt_digit[1:0] != 2'd3) && lz_run) cur_pat = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk_300Hz or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= 8'h00;
      an_q    <= 8'hFF;
      shown_q <= 2'd0;
      fs_q    <= 1'b0;
    end else begin
      fs_q    <= (state == LATCH);
      shown_q <= nxt_bank;
      an_q    <= (nxt_state == ON) ? ~(8'h01 << nxt_digit) : 8'hFF;
      if (nxt_state != ON)
        seg_q <= 8'h00;
      else if (enter_on)
        seg_q <= cur_pat;
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.an_n        = an_q;
  assign bus.shown_bank  = shown_q;
  assign bus.frame_start = fs_q;
  assign bus.bank_valid  = valid_q;

endmodule
